// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared constants and helpers for the Rijndael ShiftRows datapath.
//   - NB_128 / NB_192 / NB_256 : the only legal state column counts (Nb)
//   - nb_is_legal(nb)          : 1 when nb is one of the legal column counts
//   - shift_of(nb, row)        : cyclic row offset used by ShiftRows
//   - idx(row, col)            : byte index of (row, col) in a column-major state
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int NB_128 = 4;
  localparam int NB_192 = 6;
  localparam int NB_256 = 8;

  function automatic logic nb_is_legal(input int nb);
    return (nb == NB_128) || (nb == NB_192) || (nb == NB_256);
  endfunction

  // Offsets are {0,1,2,3} for Nb=4/6; the 256-bit block widens rows 2 and 3
  // to {3,4} so that every row still lands in a distinct column set.
  function automatic int shift_of(input int nb, input int row);
    if ((nb == NB_256) && (row >= 2)) begin
      return row + 1;
    end
    return row;
  endfunction

  // State bytes are stored column after column, four rows per column.
  function automatic int idx(input int row, input int col);
    return 4 * col + row;
  endfunction

endpackage

// File: rtl/aes_shift_rows_perm.sv
// -----------------------------------------------------------------------------
// aes_shift_rows_perm
// Purely combinational (Inv)ShiftRows byte permutation.
// Parameters:
//   NB   : state columns, 4, 6 or 8
// Ports:
//   data : input state, big-endian, byte k = data[8k:8k+7]
//   inv  : 0 = ShiftRows, 1 = InvShiftRows
//   perm : permuted state, same byte ordering as data
// -----------------------------------------------------------------------------
module aes_shift_rows_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [0:32*NB-1] data,
  input  logic             inv,
  output logic [0:32*NB-1] perm
);

  if (!nb_is_legal(NB)) begin : g_bad_nb
    $error("aes_shift_rows_perm: NB must be 4, 6 or 8");
  end

  // Each output byte is a fixed wire pick from one of two source bytes; the
  // source columns are resolved at elaboration so only a 2:1 mux remains.
  for (genvar gi = 0; gi < NB; gi++) begin : g_col
    for (genvar gr = 0; gr < 4; gr++) begin : g_row
      localparam int SHIFT   = shift_of(NB, gr);
      localparam int FWD_COL = (gi + SHIFT) % NB;
      localparam int INV_COL = (gi + NB - SHIFT) % NB;
      localparam int DST     = idx(gr, gi);
      localparam int FWD_SRC = idx(gr, FWD_COL);
      localparam int INV_SRC = idx(gr, INV_COL);

      assign perm[8*DST +: 8] = inv ? data[8*INV_SRC +: 8]
                                    : data[8*FWD_SRC +: 8];
    end
  end

endmodule

// File: rtl/aes_shift_rows_stage.sv
// -----------------------------------------------------------------------------
// aes_shift_rows_stage
// One-cycle valid/ready pipeline stage applying ShiftRows or InvShiftRows to
// an AES/Rijndael state. The permutation sits in front of the output flops, so
// out_data/out_valid/out_inv come straight from registers.
//
// Build option:
//   AES_SHIFT_ROWS_SKID_EN defined   : one-entry skid buffer, in_ready is a
//                                      flop (no out_ready -> in_ready path),
//                                      up to 2 beats held, full rate kept.
//   AES_SHIFT_ROWS_SKID_EN undefined : in_ready = !out_valid || out_ready,
//                                      at most 1 beat held.
//
// Parameters:
//   NB        : state columns, 4, 6 or 8 (state width 32*NB bits)
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : input beat present
//   in_ready  : stage accepts a beat this cycle
//   in_inv    : 0 = ShiftRows, 1 = InvShiftRows, per beat
//   in_data   : input state, byte k = in_data[8k:8k+7]
//   out_valid : output beat present
//   out_ready : consumer accepts the output beat
//   out_inv   : mode that travelled with the beat
//   out_data  : permuted state, same byte ordering as in_data
// -----------------------------------------------------------------------------
module aes_shift_rows_stage
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_inv,
  input  logic [0:32*NB-1] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_inv,
  output logic [0:32*NB-1] out_data
);

  localparam int W = 32 * NB;

  if (!nb_is_legal(NB)) begin : g_bad_nb
    $error("aes_shift_rows_stage: NB must be 4, 6 or 8");
  end

  logic [0:W-1] perm_data;
  logic         in_fire;
  logic         out_free;

  logic         out_valid_reg, out_valid_next;
  logic         out_inv_reg,   out_inv_next;
  logic [0:W-1] out_data_reg,  out_data_next;

  aes_shift_rows_perm #(
    .NB (NB)
  ) u_perm (
    .data (in_data),
    .inv  (in_inv),
    .perm (perm_data)
  );

  assign in_fire  = in_valid && in_ready;
  // The output register may take a new beat when empty or being drained now.
  assign out_free = !out_valid_reg || out_ready;

`ifdef AES_SHIFT_ROWS_SKID_EN

  logic         skid_valid_reg, skid_valid_next;
  logic         skid_inv_reg,   skid_inv_next;
  logic [0:W-1] skid_data_reg,  skid_data_next;
  logic         in_ready_reg,   in_ready_next;

  assign in_ready = in_ready_reg;

  always_comb begin
    out_valid_next  = out_valid_reg;
    out_inv_next    = out_inv_reg;
    out_data_next   = out_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_inv_next   = skid_inv_reg;
    skid_data_next  = skid_data_reg;

    if (skid_valid_reg) begin
      // in_ready is low while the skid entry is full, so no new beat can
      // arrive here; the parked beat moves forward as soon as there is room.
      if (out_free) begin
        out_valid_next  = 1'b1;
        out_inv_next    = skid_inv_reg;
        out_data_next   = skid_data_reg;
        skid_valid_next = 1'b0;
      end
    end else if (in_fire) begin
      if (out_free) begin
        out_valid_next = 1'b1;
        out_inv_next   = in_inv;
        out_data_next  = perm_data;
      end else begin
        // Output is stalled: park the beat (already permuted) in the skid.
        skid_valid_next = 1'b1;
        skid_inv_next   = in_inv;
        skid_data_next  = perm_data;
      end
    end else if (out_free) begin
      out_valid_next = 1'b0;
    end

    // Registered ready: look ahead at next cycle's skid occupancy so that
    // ready drops exactly while the skid entry holds a beat.
    in_ready_next = !skid_valid_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid_reg <= 1'b0;
      skid_inv_reg   <= 1'b0;
      skid_data_reg  <= '0;
      in_ready_reg   <= 1'b1;
    end else begin
      skid_valid_reg <= skid_valid_next;
      skid_inv_reg   <= skid_inv_next;
      skid_data_reg  <= skid_data_next;
      in_ready_reg   <= in_ready_next;
    end
  end

`else

  // Single holding register: accept whenever it will be free at the edge.
  assign in_ready = out_free;

  always_comb begin
    out_valid_next = out_valid_reg;
    out_inv_next   = out_inv_reg;
    out_data_next  = out_data_reg;

    if (in_fire) begin
      out_valid_next = 1'b1;
      out_inv_next   = in_inv;
      out_data_next  = perm_data;
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end
  end

`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_inv_reg   <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      out_valid_reg <= out_valid_next;
      out_inv_reg   <= out_inv_next;
      out_data_reg  <= out_data_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_inv   = out_inv_reg;
  assign out_data  = out_data_reg;

endmodule

// File: tb/tb_aes_shift_rows_stage.sv
// -----------------------------------------------------------------------------
// tb_aes_shift_rows_stage
// Self-checking bench for aes_shift_rows_stage. A NB=4 instance is driven with
// directed and random handshakes against a row-rotation reference model and a
// beat scoreboard; a NB=8 instance checks the wider offsets.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_aes_shift_rows_stage;

`ifdef AES_SHIFT_ROWS_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic           in_valid  = 1'b0;
  logic           in_ready;
  logic           in_inv    = 1'b0;
  logic [0:127]   in_data   = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           out_inv;
  logic [0:127]   out_data;

  logic           in8_valid  = 1'b0;
  logic           in8_ready;
  logic           in8_inv    = 1'b0;
  logic [0:255]   in8_data   = '0;
  logic           out8_valid;
  logic           out8_ready = 1'b1;
  logic           out8_inv;
  logic [0:255]   out8_data;

  always #5 clk = ~clk;

  aes_shift_rows_stage #(.NB(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inv    (in_inv),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inv   (out_inv),
    .out_data  (out_data)
  );

  aes_shift_rows_stage #(.NB(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in8_valid),
    .in_ready  (in8_ready),
    .in_inv    (in8_inv),
    .in_data   (in8_data),
    .out_valid (out8_valid),
    .out_ready (out8_ready),
    .out_inv   (out8_inv),
    .out_data  (out8_data)
  );

  typedef struct packed {
    logic         inv;
    logic [0:127] data;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fails  = 0;
  int    n_pops   = 0;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  // Reference: lay the state out as a 4 x nb matrix, rotate each row by its
  // offset (left for forward, right for inverse), then flatten again.
  function automatic logic [0:255] ref_shift_rows(input logic [0:255] d, input int nb, input bit inv);
    logic [7:0]   m   [4][8];
    logic [7:0]   rot [4][8];
    int           sh  [4];
    logic [0:255] o;
    sh[0] = 0;
    sh[1] = 1;
    sh[2] = (nb == 8) ? 3 : 2;
    sh[3] = (nb == 8) ? 4 : 3;
    for (int k = 0; k < 4*nb; k++) m[k%4][k/4] = d[8*k +: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < nb; c++)
        rot[r][c] = inv ? m[r][(c + nb - sh[r]) % nb] : m[r][(c + sh[r]) % nb];
    o = '0;
    for (int k = 0; k < 4*nb; k++) o[8*k +: 8] = rot[k%4][k/4];
    return o;
  endfunction

  function automatic logic [0:127] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock of the NB=4 instance. Entered at posedge+1 with inputs driven;
  // checks outputs against the scoreboard, then tracks the handshake.
  task automatic cycle();
    bit           fire_in;
    bit           fire_out;
    bit           want_ready;
    logic [0:255] r;
    beat_t        b;
    #1;
    if (!rst) begin
      check_val("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check_val("out_data", out_data, exp_q[0].data);
        check_val("out_inv", out_inv, exp_q[0].inv);
      end
      want_ready = SKID ? (exp_q.size() < 2) : ((exp_q.size() == 0) || out_ready);
      check_val("in_ready", in_ready, want_ready);
      check_val("occupancy", exp_q.size() <= (SKID ? 2 : 1), 1'b1);
    end
    fire_in  = in_valid && in_ready;
    fire_out = out_valid && out_ready;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
    end else begin
      if (fire_out && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        n_pops++;
      end
      if (fire_in) begin
        r      = ref_shift_rows({in_data, 128'h0}, 4, in_inv);
        b.inv  = in_inv;
        b.data = r[0:127];
        exp_q.push_back(b);
      end
    end
    #1;
  endtask

  initial begin
    logic [0:127] held;
    logic [0:255] r8;
    logic [0:255] v8;
    logic [0:31]  col0;
    int           p0;
    int           cyc;

    // ---------------- reset ----------------
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_out_data", out_data, '0);
    check_val("rst_out_inv", out_inv, 1'b0);
    check_val("rst_in_ready", in_ready, 1'b1);
    check_val("rst_out8_valid", out8_valid, 1'b0);
    check_val("rst_in8_ready", in8_ready, 1'b1);

    // ---------------- directed NB=4 forward / inverse ----------------
    in_valid = 1'b1; in_inv = 1'b0; out_ready = 1'b0;
    in_data  = 128'h000102030405060708090A0B0C0D0E0F;
    cycle();
    in_valid = 1'b0;
    check_val("fwd_valid", out_valid, 1'b1);
    check_val("fwd_data", out_data, 128'h00050A0F04090E03080D02070C01060B);
    check_val("fwd_inv", out_inv, 1'b0);
    out_ready = 1'b1;
    cycle();

    in_valid = 1'b1; in_inv = 1'b1; out_ready = 1'b0;
    in_data  = 128'h00050A0F04090E03080D02070C01060B;
    cycle();
    in_valid = 1'b0;
    check_val("inv_valid", out_valid, 1'b1);
    check_val("inv_data", out_data, 128'h000102030405060708090A0B0C0D0E0F);
    check_val("inv_inv", out_inv, 1'b1);
    out_ready = 1'b1;
    cycle();

    // ---------------- NB=8 instance ----------------
    for (int k = 0; k < 32; k++) in8_data[8*k +: 8] = 8'(k);
    in8_valid = 1'b1; in8_inv = 1'b0; out8_ready = 1'b1;
    v8 = in8_data;
    @(posedge clk); #1;
    in8_valid = 1'b0;
    r8   = out8_data;
    col0 = r8[0:31];
    check_val("nb8_valid", out8_valid, 1'b1);
    check_val("nb8_col0", col0, 32'h00050E13);
    check_val("nb8_full", out8_data, ref_shift_rows(v8, 8, 1'b0));
    for (int i = 0; i < 24; i++) begin
      in8_valid = 1'b1;
      in8_inv   = 1'($urandom);
      in8_data  = {rand128(), rand128()};
      v8        = in8_data;
      check_val("nb8_in_ready", in8_ready, 1'b1);
      @(posedge clk); #1;
      check_val("nb8_rand_valid", out8_valid, 1'b1);
      check_val("nb8_rand_data", out8_data, ref_shift_rows(v8, 8, in8_inv));
      check_val("nb8_rand_inv", out8_inv, in8_inv);
    end
    in8_valid = 1'b0;

    // ---------------- full-rate throughput ----------------
    in_valid = 1'b1; out_ready = 1'b1;
    p0 = n_pops;
    for (int i = 0; i < 50; i++) begin
      in_inv  = 1'($urandom);
      in_data = rand128();
      cycle();
    end
    in_valid = 1'b0;
    check_val("throughput_pops", n_pops - p0, 49);
    repeat (2) cycle();

    // ---------------- stall with one beat held ----------------
    in_valid = 1'b1; in_inv = 1'b0; in_data = rand128(); out_ready = 1'b0;
    cycle();
    held     = out_data;
    in_inv   = 1'b1; in_data = rand128();
    p0       = n_pops;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_val("stall_stable", out_data, held);
    end
    check_val("stall_held_beats", exp_q.size(), SKID ? 2 : 1);
    in_valid  = !SKID;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (4) cycle();
    check_val("stall_drained_pops", n_pops - p0, 2);
    check_val("stall_queue_empty", exp_q.size(), 0);

    // ---------------- randomized scoreboard run ----------------
    p0  = n_pops;
    cyc = 0;
    while ((n_pops - p0 < 10000) && (cyc < 60000)) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      in_inv    = 1'($urandom);
      in_data   = rand128();
      out_ready = ($urandom_range(0, 99) < 70);
      cycle();
      cyc++;
    end
    check_val("rand_beats_done", n_pops - p0, 10000);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();
    check_val("rand_queue_empty", exp_q.size(), 0);

    // ---------------- reset with beats in flight ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1; in_inv = 1'b0; in_data = rand128();
    cycle();
    in_inv = 1'b1; in_data = rand128();
    cycle();
    rst = 1'b1; in_data = rand128();
    cycle();
    rst = 1'b0; in_valid = 1'b0;
    check_val("midrst_out_valid", out_valid, 1'b0);
    check_val("midrst_out_data", out_data, '0);
    check_val("midrst_out_inv", out_inv, 1'b0);
    check_val("midrst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    p0 = n_pops;
    repeat (8) cycle();
    check_val("midrst_no_stale", n_pops - p0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/aes_shift_rows_stage.md
AES_SHIFT_ROWS_STAGE -- requirements
Module: aes_shift_rows_stage

Interface
REQ-001 Parameter NB, default 4, meaning state columns (Rijndael Nb); legal values 4, 6, 8 only.
REQ-002 Derived constant W = 32*NB, the state width in bits.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  the input beat is present.
REQ-006 in_ready  output  1  the stage accepts a beat this cycle.
REQ-007 in_inv  input  1  0 selects ShiftRows, 1 selects InvShiftRows.
REQ-008 in_data  input  [0:W-1]  state, big-endian; byte k = in_data[8k:8k+7]; row r = k mod 4, column c = k div 4.
REQ-009 out_valid  output  1  the output beat is present.
REQ-010 out_ready  input  1  the consumer accepts the output beat.
REQ-011 out_inv  output  1  the in_inv value that travelled with the beat.
REQ-012 out_data  output  [0:W-1]  permuted state, same byte ordering as in_data.

Function
REQ-013 Row offsets SHALL be s = {0,1,2,3} for NB=4 and NB=6, and s = {0,1,3,4} for NB=8.
- Forward mode: out[r][c] = in[r][(c+s_r) mod NB].
- Inverse mode: out[r][c] = in[r][(c-s_r) mod NB], with column indices wrapping modulo NB.
REQ-014 A beat SHALL transfer on the input when in_valid and in_ready are both 1 in the same cycle, and on the output when out_valid and out_ready are both 1.
REQ-015 Latency SHALL be exactly one cycle: a beat accepted in cycle t is presented with out_valid=1 in cycle t+1.
REQ-016 The permutation SHALL be computed on the input side; out_data, out_valid and out_inv SHALL be driven directly from flops.
REQ-017 While out_valid=1 and out_ready=0, out_data and out_inv SHALL hold stable.
REQ-018 Mode SHALL be selectable per beat; back-to-back beats of differing mode SHALL each use their own mode.
REQ-019 Simultaneous output pop and input push in one cycle SHALL give sustained throughput of one beat per cycle, with no bubble.
REQ-020 Beats SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-021 Inputs while in_valid=0 SHALL be ignored.

Reset
REQ-022 rst=1 at a clock edge SHALL set out_valid=0, out_data=0, out_inv=0 and clear all internal valid and holding state.
REQ-023 From the first cycle after reset, in_ready SHALL be 1.
REQ-024 A beat presented during a cycle in which rst=1 SHALL be discarded.
REQ-025 Reset asserted mid-stream SHALL discard all in-flight beats.

Configuration
REQ-026 Macro AES_SHIFT_ROWS_SKID_EN controls the skid buffer.
- Defined: a one-entry skid buffer is present; in_ready is a flop output with no combinational path from out_ready; full rate is kept; at most 2 beats are held; in_ready falls only while the skid entry is occupied.
- Undefined: in_ready = !out_valid || out_ready, combinationally, and at most 1 beat is held.

Structure
REQ-027 Shared package aes_pkg SHALL hold:
- the legal-NB constants;
- the row-offset function shift_of(nb, row);
- the byte-index helper idx(row, col) = 4*col + row.
REQ-028 One combinational sub-module, aes_shift_rows_perm (parameter NB; inputs data and inv; output the permuted data), SHALL be instantiated once, on the input path.
REQ-029 An NB outside {4,6,8} SHALL cause an elaboration error.

Verification
REQ-030 NB=4, forward, in_data=0x000102030405060708090A0B0C0D0E0F -> one cycle later out_valid=1, out_data=0x00050A0F04090E03080D02070C01060B, out_inv=0.
REQ-031 NB=4, inverse, in_data=0x00050A0F04090E03080D02070C01060B -> out_data=0x000102030405060708090A0B0C0D0E0F, out_inv=1.
REQ-032 NB=8, forward, in_data = bytes 0x00..0x1F -> output column 0 = bytes 00 05 0E 13.
REQ-033 Random modes, both macro settings, random in_valid/out_ready over 10000 beats -> scoreboard exact; with both handshakes held at 1, 1 beat/cycle.
REQ-034 out_ready=0 for 5 cycles with one beat held -> out_data stable; second beat accepted per REQ-026; no loss.
REQ-035 rst=1 pulse with 2 beats in flight -> next cycle out_valid=0, out_data=0, in_ready=1; no stale beat appears afterwards.
